// File: rtl/gpio_reg_arbiter.sv
// Two-requester round-robin arbiter for the GPIO register-file port.
// The winning command is latched and held on the port until gpio_ready or timeout, then acked for one cycle.
module gpio_reg_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic [1:0]              req,
    input  logic [1:0]              req_wr,
    input  logic [ADDR_WIDTH-1:0]   req_addr0,
    input  logic [ADDR_WIDTH-1:0]   req_addr1,
    input  logic [DATA_WIDTH-1:0]   req_wdata0,
    input  logic [DATA_WIDTH-1:0]   req_wdata1,
    input  logic [DATA_WIDTH/8-1:0] req_strb0,
    input  logic [DATA_WIDTH/8-1:0] req_strb1,
    output logic [1:0]              ack,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_error,
    output logic                    gpio_wr_en,
    output logic                    gpio_rd_en,
    output logic [ADDR_WIDTH-1:0]   gpio_reg_addr,
    output logic [DATA_WIDTH-1:0]   gpio_wdata,
    output logic [DATA_WIDTH/8-1:0] gpio_strb,
    input  logic [DATA_WIDTH-1:0]   gpio_rdata,
    input  logic                    gpio_ready,
    input  logic                    gpio_error,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       rr_ptr;
    logic       grant_q;
    logic       wr_q;
    logic       win;
    logic [7:0] cnt;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        win       = rr_ptr;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            default: win = rr_ptr;
        endcase

        case (state)
            IDLE:    if (|req) state_nxt = ACCESS;
            ACCESS:  if (gpio_ready || cnt == CNT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        // NOTE: reset is sampled on the clock edge here, so it must sit inside the clocked branch, not the sensitivity list.
        if (!PRESETn) begin
            state         <= IDLE;
            rr_ptr        <= 1'b0;
            grant_q       <= 1'b0;
            wr_q          <= 1'b0;
            cnt           <= '0;
            rsp_rdata     <= '0;
            rsp_error     <= 1'b0;
            gpio_reg_addr <= '0;
            gpio_wdata    <= '0;
            gpio_strb     <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop sees pre-edge values.
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant_q       <= win;
                        wr_q          <= req_wr[win];
                        gpio_reg_addr <= win ? req_addr1  : req_addr0;
                        gpio_wdata    <= win ? req_wdata1 : req_wdata0;
                        gpio_strb     <= win ? req_strb1  : req_strb0;
                        cnt           <= '0;
                    end
                end
                ACCESS: begin
                    // gpio_ready takes priority over a timeout landing in the same cycle
                    if (gpio_ready) begin
                        rsp_rdata <= wr_q ? '0 : gpio_rdata;
                        rsp_error <= gpio_error;
                    end else if (cnt == CNT_LAST) begin
                        rsp_rdata <= '0;
                        rsp_error <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE:    rr_ptr <= ~grant_q;
                default: ;
            endcase
        end
    end

    // Strobes and ack decode only from registered state, keeping them glitch-free
    assign gpio_wr_en = (state == ACCESS) &&  wr_q;
    assign gpio_rd_en = (state == ACCESS) && !wr_q;
    assign ack        = (state == DONE) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_gpio_reg_arbiter.sv
// Directed self-checking bench for gpio_reg_arbiter: reset, single write, waited read,
// contention, timeout boundary and reset mid-access.
module tb_gpio_reg_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [1:0]  req;
    logic [1:0]  req_wr;
    logic [31:0] req_addr0, req_addr1;
    logic [31:0] req_wdata0, req_wdata1;
    logic [3:0]  req_strb0, req_strb1;
    logic [1:0]  ack;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        gpio_wr_en, gpio_rd_en;
    logic [31:0] gpio_reg_addr, gpio_wdata;
    logic [3:0]  gpio_strb;
    logic [31:0] gpio_rdata;
    logic        gpio_ready, gpio_error;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_reg_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(16)) dut (
        .PCLK          (PCLK),
        .PRESETn       (PRESETn),
        .req           (req),
        .req_wr        (req_wr),
        .req_addr0     (req_addr0),
        .req_addr1     (req_addr1),
        .req_wdata0    (req_wdata0),
        .req_wdata1    (req_wdata1),
        .req_strb0     (req_strb0),
        .req_strb1     (req_strb1),
        .ack           (ack),
        .rsp_rdata     (rsp_rdata),
        .rsp_error     (rsp_error),
        .gpio_wr_en    (gpio_wr_en),
        .gpio_rd_en    (gpio_rd_en),
        .gpio_reg_addr (gpio_reg_addr),
        .gpio_wdata    (gpio_wdata),
        .gpio_strb     (gpio_strb),
        .gpio_rdata    (gpio_rdata),
        .gpio_ready    (gpio_ready),
        .gpio_error    (gpio_error),
        .busy          (busy)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Issues req from IDLE, plays the register port (ready on strobe cycle ready_at, 0 = never),
    // checks the ack cycle, then steps into the following IDLE cycle.
    task automatic txn(input string tag, input logic [1:0] r, input int ready_at,
                       input logic [31:0] rd_in, input logic err_in,
                       input logic [1:0] exp_ack, input logic exp_wr, input logic [31:0] exp_addr,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_strobes, input logic [1:0] r_after);
        int          strobes = 0;
        int          lat     = 0;
        bit          done    = 0;
        logic [31:0] a0      = req_addr0;
        logic [31:0] a1      = req_addr1;
        req        = r;
        gpio_ready = 1'b0;
        while (!done && lat < 300) begin
            tick();
            lat++;
            if (ack != 2'b00) begin
                check({tag, "_ack"},     64'(ack),       64'(exp_ack));
                check({tag, "_rdata"},   64'(rsp_rdata), 64'(exp_rdata));
                check({tag, "_error"},   64'(rsp_error), 64'(exp_err));
                check({tag, "_strobes"}, 64'(strobes),   64'(exp_strobes));
                check({tag, "_latency"}, 64'(lat),       64'(exp_strobes + 1));
                check({tag, "_done_strobe"}, 64'({gpio_wr_en, gpio_rd_en}), 64'(2'b00));
                req        = r_after;
                gpio_ready = 1'b0;
                done       = 1;
            end else if (gpio_wr_en || gpio_rd_en) begin
                strobes++;
                if (strobes == 1) begin
                    check({tag, "_dir"},   64'({gpio_wr_en, gpio_rd_en}), 64'({exp_wr, ~exp_wr}));
                    check({tag, "_wdata"}, 64'(gpio_wdata), 64'(exp_wdata));
                end
                check({tag, "_addr"}, 64'(gpio_reg_addr), 64'(exp_addr));
                if (strobes == 2) begin
                    req_addr0 = 32'hFFFF_FFF0;
                    req_addr1 = 32'hFFFF_FFF4;
                end
                gpio_ready = (strobes == ready_at);
                gpio_rdata = rd_in;
                gpio_error = err_in;
            end else begin
                gpio_ready = 1'b0;
            end
        end
        if (!done) check({tag, "_no_ack"}, 64'(ack), 64'(exp_ack));
        req_addr0  = a0;
        req_addr1  = a1;
        gpio_error = 1'b0;
        tick();
        check({tag, "_idle_busy"}, 64'(busy), 64'(1'b0));
        check({tag, "_hold"},      64'(rsp_rdata), 64'(exp_rdata));
    endtask

    initial begin
        PRESETn    = 1'b0;
        req        = 2'b11;
        req_wr     = 2'b01;
        req_addr0  = 32'h0000_0008;
        req_addr1  = 32'h0000_0004;
        req_wdata0 = 32'hA5A5_0F0F;
        req_wdata1 = 32'h1234_5678;
        req_strb0  = 4'b1111;
        req_strb1  = 4'b0011;
        gpio_rdata = 32'h0;
        gpio_ready = 1'b0;
        gpio_error = 1'b0;

        // Reset held two cycles with both requesting
        tick();
        tick();
        check("rst_ack",    64'(ack),  64'(2'b00));
        check("rst_strobe", 64'({gpio_wr_en, gpio_rd_en}), 64'(2'b00));
        check("rst_busy",   64'(busy), 64'(1'b0));
        check("rst_rdata",  64'(rsp_rdata), 64'(0));
        check("rst_addr",   64'(gpio_reg_addr), 64'(0));
        PRESETn = 1'b1;

        // First grant after reset goes to requester 0
        txn("rst_rr", 2'b11, 1, 32'h0, 1'b0, 2'b01, 1'b1, 32'h08, 32'hA5A5_0F0F,
            32'h0, 1'b0, 1, 2'b00);

        // Single write
        txn("wr1", 2'b01, 1, 32'h0, 1'b0, 2'b01, 1'b1, 32'h08, 32'hA5A5_0F0F,
            32'h0, 1'b0, 1, 2'b00);

        // Read with 4 wait cycles
        txn("rd_wait", 2'b10, 4, 32'h0000_00FF, 1'b0, 2'b10, 1'b0, 32'h04, 32'h1234_5678,
            32'h0000_00FF, 1'b0, 4, 2'b00);

        // Contention: both held, grants alternate, error passed through on the third
        txn("cont0", 2'b11, 1, 32'h0,         1'b0, 2'b01, 1'b1, 32'h08, 32'hA5A5_0F0F,
            32'h0,         1'b0, 1, 2'b11);
        txn("cont1", 2'b11, 1, 32'hCAFE_0001, 1'b0, 2'b10, 1'b0, 32'h04, 32'h1234_5678,
            32'hCAFE_0001, 1'b0, 1, 2'b11);
        txn("cont2", 2'b11, 1, 32'hBEEF_0000, 1'b1, 2'b01, 1'b1, 32'h08, 32'hA5A5_0F0F,
            32'h0,         1'b1, 1, 2'b11);
        txn("cont3", 2'b11, 1, 32'hCAFE_0002, 1'b0, 2'b10, 1'b0, 32'h04, 32'h1234_5678,
            32'hCAFE_0002, 1'b0, 1, 2'b00);

        // Timeout: ready never comes
        txn("tmo", 2'b10, 0, 32'hDEAD_BEEF, 1'b0, 2'b10, 1'b0, 32'h04, 32'h1234_5678,
            32'h0, 1'b1, 16, 2'b00);

        // Ready on the last allowed cycle beats the timeout
        txn("tmo_edge", 2'b10, 16, 32'h0000_0055, 1'b0, 2'b10, 1'b0, 32'h04, 32'h1234_5678,
            32'h0000_0055, 1'b0, 16, 2'b00);

        // Move rr_ptr to 1, then reset on the second ACCESS cycle of a requester-1 read
        txn("pre_rst", 2'b01, 1, 32'h0, 1'b0, 2'b01, 1'b1, 32'h08, 32'hA5A5_0F0F,
            32'h0, 1'b0, 1, 2'b00);
        req = 2'b11;
        tick();
        check("mid_acc1_rd",   64'({gpio_wr_en, gpio_rd_en}), 64'(2'b01));
        check("mid_acc1_addr", 64'(gpio_reg_addr), 64'(32'h04));
        tick();
        check("mid_acc2_busy", 64'(busy), 64'(1'b1));
        check("mid_acc2_ack",  64'(ack),  64'(2'b00));
        PRESETn = 1'b0;
        tick();
        check("mid_rst_strobe", 64'({gpio_wr_en, gpio_rd_en}), 64'(2'b00));
        check("mid_rst_ack",    64'(ack),  64'(2'b00));
        check("mid_rst_busy",   64'(busy), 64'(1'b0));
        tick();
        check("mid_rst_ack2",   64'(ack),  64'(2'b00));
        PRESETn = 1'b1;
        txn("post_rst", 2'b11, 1, 32'h0, 1'b0, 2'b01, 1'b1, 32'h08, 32'hA5A5_0F0F,
            32'h0, 1'b0, 1, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_reg_arbiter.md
Name: gpio_reg_arbiter

Overview:
- Two-requester arbiter and sequencer for the single GPIO register-file port (gpio_wr_en/gpio_rd_en/addr/wdata/strb in; rdata/ready/error out).
- Requester 0 is the APB slave front end; requester 1 is an internal agent such as an interrupt/debounce update engine.
- Grants round-robin, latches the winning command, holds it on the register port until gpio_ready or timeout, then returns a one-cycle ack with read data and error.

Parameters:
DATA_WIDTH, 32, data bus width (matches `DATA_WIDTH)
ADDR_WIDTH, 32, register address width (matches `ADDR_WIDTH)
TIMEOUT, 16, max ACCESS cycles waiting for gpio_ready; 2..255

Ports:
PCLK  in  1  clock
PRESETn  in  1  synchronous active-low reset
req  in  2  request per requester, held until ack
req_wr  in  2  per-requester 1=write 0=read
req_addr0, req_addr1  in  ADDR_WIDTH  per-requester register address
req_wdata0, req_wdata1  in  DATA_WIDTH  per-requester write data
req_strb0, req_strb1  in  DATA_WIDTH/8  per-requester byte strobes
ack  out  2  one-hot, one-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  read data, valid with ack
rsp_error  out  1  error, valid with ack
gpio_wr_en, gpio_rd_en  out  1  register-port strobes
gpio_reg_addr  out  ADDR_WIDTH  latched address
gpio_wdata  out  DATA_WIDTH  latched write data
gpio_strb  out  DATA_WIDTH/8  latched strobes
gpio_rdata  in  DATA_WIDTH  register read data
gpio_ready  in  1  register port completes this cycle
gpio_error  in  1  register port error, sampled with gpio_ready
busy  out  1  state != IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock is PCLK. Reset is PRESETn. Everything is sampled on the PCLK rising edge.
- Reset values:
  - state=IDLE, rr_ptr=0, ack=0, rsp_rdata=0, rsp_error=0.
  - gpio_wr_en=0, gpio_rd_en=0.
  - gpio_reg_addr/wdata/strb=0, timeout counter=0, busy=0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any req bit is set, pick a winner. When both are set, the winner is rr_ptr; otherwise it is the single requester.
  - Latch wr/addr/wdata/strb of the winner into the hold registers, record grant id, clear the counter, go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - gpio_wr_en=wr_q and gpio_rd_en=~wr_q. Exactly one is high. Both are decoded from state/wr_q only, so they are glitch-free.
  - Address, data and strobes hold stable.
  - If gpio_ready=1: capture rsp_rdata (gpio_rdata for reads, 0 for writes) and rsp_error=gpio_error, then go to DONE.
  - Else if counter==TIMEOUT-1: rsp_rdata=0, rsp_error=1, go to DONE.
  - Else increment the counter.
- DONE:
  - ack[grant]=1 for exactly this cycle. rsp_rdata/rsp_error hold until the next DONE.
  - rr_ptr=~grant. Strobes are 0. Go to IDLE.
  - req is ignored in DONE.
- Requester rule: deassert req on the edge where ack is seen. A req still high in the following IDLE cycle is a new request.
- Latency: req to ack is 3 cycles minimum (IDLE→ACCESS→DONE) with gpio_ready in the first ACCESS cycle. The maximum is TIMEOUT+2.
- Back-to-back: the losing requester is granted in the IDLE cycle after DONE. No requester is starved for more than one transaction.
- Request inputs changing during ACCESS have no effect, because the command is latched.
- Reset asserted mid-ACCESS:
  - Return to reset values on that edge.
  - No ack is issued, so the requester must reissue.
  - The register port strobes drop the same cycle reset is sampled.
- Simultaneous gpio_ready and timeout in the same cycle: gpio_ready wins and no timeout error is flagged.
- gpio_error is ignored outside ACCESS.

Test Plan:
- Reset: hold PRESETn=0 for 2 cycles with req=2'b11 → ack=0, strobes 0, busy=0; after release, requester 0 is granted first (rr_ptr=0).
- Single write:
  - Stimulus: req0, wr=1, addr=0x08, wdata=0xA5A5_0F0F, strb=4'b1111; gpio_ready=1 immediately.
  - Required response: gpio_wr_en high for exactly 1 cycle with addr=0x08, ack=2'b01 on cycle 3, rsp_error=0.
- Read with wait:
  - Stimulus: req1, read addr=0x04; gpio_ready asserted on the 4th ACCESS cycle with gpio_rdata=0x0000_00FF.
  - Required response: gpio_rd_en high for 4 cycles, ack=2'b10, rsp_rdata=0xFF.
- Contention: req=2'b11 held continuously, each access ready in 1 cycle → grants alternate 0,1,0,1, and the ack sequence is 01,10,01,10 every 3 cycles.
- Timeout: TIMEOUT=16, gpio_ready held 0 → strobe high for exactly 16 cycles, then ack with rsp_error=1 and rsp_rdata=0. A second run with gpio_ready=1 on the 16th cycle gives rsp_error=gpio_error=0.
- Reset mid-access: PRESETn=0 on the 2nd ACCESS cycle → strobes 0 the next cycle, no ack pulse, state IDLE, rr_ptr=0.
